// File: rtl/servo_slew_ctrl.sv
// servo_slew_ctrl: command stage in front of the servo PWM generator.
// Takes target pulse widths over valid/ready and clamps them to the servo
// range. Once per frame it moves pulse_width toward the target by at most
// STEP clocks, so the PWM stage sees a value that stays constant per frame.
//
// state | meaning
// IDLE  | pulse_width equals the applied target
// SLEW  | pulse_width still stepping toward the applied target
module servo_slew_ctrl #(
  parameter int FRAME_CLKS = 1000000,
  parameter int MIN_PW     = 50000,
  parameter int MAX_PW     = 100000,
  parameter int STEP       = 500,
  parameter int PW_W       = 17,
  parameter int CNT_W      = 20
) (
  input  logic            mclk,
  input  logic            rst,
  input  logic            enable,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [PW_W-1:0] cmd_pw,
  output logic [PW_W-1:0] pulse_width,
  output logic            frame_start,
  output logic            at_target,
  output logic            busy
);

  localparam logic [PW_W-1:0]        MIN_V      = PW_W'(MIN_PW);
  localparam logic [PW_W-1:0]        MAX_V      = PW_W'(MAX_PW);
  localparam logic [PW_W-1:0]        MID_V      = PW_W'((MIN_PW + MAX_PW) / 2);
  localparam logic [PW_W-1:0]        STEP_V     = PW_W'(STEP);
  localparam logic signed [PW_W:0]   STEP_S     = (PW_W+1)'(STEP);
  localparam logic [CNT_W-1:0]       FRAME_LAST = CNT_W'(FRAME_CLKS - 1);

  typedef enum logic {IDLE = 1'b0, SLEW = 1'b1} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [PW_W-1:0]        target;
  logic [PW_W-1:0]        pend;
  logic                   pend_valid;

  logic                   frame_wrap;
  logic [PW_W-1:0]        cmd_clamped;
  logic [PW_W-1:0]        new_target;
  logic signed [PW_W:0]   diff;
  logic [PW_W-1:0]        pw_next;

  assign frame_wrap = (cnt == FRAME_LAST);
  assign cmd_ready  = !pend_valid;
  assign busy       = (state == SLEW);
  assign at_target  = (pulse_width == target) && !pend_valid;

  // Clamp the incoming command and work out the value applied at the next frame edge.
  always_comb begin
    cmd_clamped = cmd_pw;
    if (cmd_pw < MIN_V) begin
      cmd_clamped = MIN_V;
    end else if (cmd_pw > MAX_V) begin
      cmd_clamped = MAX_V;
    end

    new_target = pend_valid ? pend : target;
    diff       = $signed({1'b0, new_target}) - $signed({1'b0, pulse_width});

    // Moving toward an in-range target can never leave the legal range.
    pw_next = pulse_width;
    if (enable) begin
      if (diff > STEP_S) begin
        pw_next = pulse_width + STEP_V;
      end else if (diff < -STEP_S) begin
        pw_next = pulse_width - STEP_V;
      end else begin
        pw_next = new_target;
      end
    end
  end

  // Free-running frame counter; frame_start is aligned with count 0.
  always_ff @(posedge mclk) begin
    if (rst) begin
      cnt         <= '0;
      frame_start <= 1'b0;
    end else begin
      if (frame_wrap) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      frame_start <= frame_wrap;
    end
  end

  // Pending slot, target and pulse width; a handshake only fills an empty slot,
  // so it never collides with the slot being drained at a frame edge.
  always_ff @(posedge mclk) begin
    if (rst) begin
      pend_valid  <= 1'b0;
      pend        <= MID_V;
      target      <= MID_V;
      pulse_width <= MID_V;
    end else begin
      if (frame_wrap) begin
        target      <= new_target;
        pulse_width <= pw_next;
        if (pend_valid) begin
          pend_valid <= 1'b0;
        end
      end
      if (cmd_valid && cmd_ready) begin
        pend       <= cmd_clamped;
        pend_valid <= 1'b1;
      end
    end
  end

  // Slew state follows whether the updated pulse width has reached the target.
  always_ff @(posedge mclk) begin
    if (rst) begin
      state <= IDLE;
    end else if (frame_wrap) begin
      case (state)
        IDLE:    state <= (pw_next != new_target) ? SLEW : IDLE;
        SLEW:    state <= (pw_next == new_target) ? IDLE : SLEW;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Bench for servo_slew_ctrl with a short frame so slews finish quickly.
module tb_servo_slew_ctrl;

  localparam int FRAME = 64;
  localparam int PW_W  = 17;

  logic            mclk;
  logic            rst;
  logic            enable;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [PW_W-1:0] cmd_pw;
  logic [PW_W-1:0] pulse_width;
  logic            frame_start;
  logic            at_target;
  logic            busy;

  int checks;
  int failures;
  int exp_q[$];

  servo_slew_ctrl #(
    .FRAME_CLKS(FRAME),
    .MIN_PW(50000),
    .MAX_PW(100000),
    .STEP(500),
    .PW_W(PW_W),
    .CNT_W(20)
  ) dut (
    .mclk(mclk),
    .rst(rst),
    .enable(enable),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_pw(cmd_pw),
    .pulse_width(pulse_width),
    .frame_start(frame_start),
    .at_target(at_target),
    .busy(busy)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_start && n < FRAME + 4);
    if (!frame_start) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout: no frame_start within %0d cycles", n);
    end
  endtask

  task automatic send_cmd(input int v);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_pw    = PW_W'(v);
    while (!cmd_ready && n < 4 * FRAME) begin
      step();
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL cmd_timeout: cmd %0d never accepted", v);
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    wait_frame();
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    step();
    step();
    checks++; if (pulse_width !== 17'd75000) begin failures++; $display("FAIL rst_pw: got %0d want 75000", pulse_width); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
    checks++; if (at_target !== 1'b1) begin failures++; $display("FAIL rst_at_target: got %b want 1", at_target); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL rst_frame_start: got %b want 0", frame_start); end
    rst = 1'b0;
    n = 0;
    do begin step(); n++; end while (!frame_start && n < FRAME + 4);
    checks++; if (n !== FRAME) begin failures++; $display("FAIL first_frame: at cycle %0d want %0d", n, FRAME); end
    n = 0;
    do begin step(); n++; end while (!frame_start && n < FRAME + 4);
    checks++; if (n !== FRAME) begin failures++; $display("FAIL frame_period: got %0d want %0d", n, FRAME); end
    step();
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL frame_start_width: got %b want 0", frame_start); end
  endtask

  task automatic test_small_step();
    int e;
    for (int i = 0; i < 10; i++) step();
    send_cmd(76000);
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL small_ready_drop: got %b want 0", cmd_ready); end
    exp_q.push_back(75500);
    exp_q.push_back(76000);
    wait_frame();
    e = exp_q.pop_front();
    checks++; if (pulse_width !== PW_W'(e)) begin failures++; $display("FAIL small_f1_pw: got %0d want %0d", pulse_width, e); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL small_f1_ready: got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL small_f1_busy: got %b want 1", busy); end
    wait_frame();
    e = exp_q.pop_front();
    checks++; if (pulse_width !== PW_W'(e)) begin failures++; $display("FAIL small_f2_pw: got %0d want %0d", pulse_width, e); end
    checks++; if (at_target !== 1'b1) begin failures++; $display("FAIL small_f2_at_target: got %b want 1", at_target); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL small_f2_busy: got %b want 0", busy); end
  endtask

  task automatic test_clamp();
    int e;
    int nexp;
    do_reset();
    send_cmd(120000);
    for (int k = 1; k <= 50; k++) exp_q.push_back(75000 + 500 * k);
    exp_q.push_back(100000);
    nexp = exp_q.size();
    for (int i = 0; i < nexp; i++) begin
      wait_frame();
      e = exp_q.pop_front();
      checks++; if (pulse_width !== PW_W'(e)) begin failures++; $display("FAIL clamp_hi_pw frame %0d: got %0d want %0d", i, pulse_width, e); end
    end
    checks++; if (busy !== 1'b0 || at_target !== 1'b1) begin failures++; $display("FAIL clamp_hi_done: busy=%b at_target=%b want 0/1", busy, at_target); end
    send_cmd(10);
    for (int k = 1; k <= 100; k++) exp_q.push_back(100000 - 500 * k);
    exp_q.push_back(50000);
    nexp = exp_q.size();
    for (int i = 0; i < nexp; i++) begin
      wait_frame();
      e = exp_q.pop_front();
      checks++; if (pulse_width !== PW_W'(e)) begin failures++; $display("FAIL clamp_lo_pw frame %0d: got %0d want %0d", i, pulse_width, e); end
    end
    checks++; if (busy !== 1'b0 || at_target !== 1'b1) begin failures++; $display("FAIL clamp_lo_done: busy=%b at_target=%b want 0/1", busy, at_target); end
  endtask

  task automatic test_back_to_back();
    int e;
    int n;
    int nexp;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    send_cmd(80000);
    exp_q.push_back(75500);
    cmd_valid = 1'b1;
    cmd_pw    = PW_W'(70000);
    n = 0;
    while (!cmd_ready && n < 2 * FRAME) begin
      step();
      n++;
    end
    checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL b2b_stall: ready returned with frame_start=%b want 1", frame_start); end
    e = exp_q.pop_front();
    checks++; if (pulse_width !== PW_W'(e)) begin failures++; $display("FAIL b2b_first_pw: got %0d want %0d", pulse_width, e); end
    step();
    cmd_valid = 1'b0;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_second_accept: ready=%b want 0", cmd_ready); end
    for (int k = 0; k <= 10; k++) exp_q.push_back(75000 - 500 * k);
    nexp = exp_q.size();
    for (int i = 0; i < nexp; i++) begin
      wait_frame();
      e = exp_q.pop_front();
      checks++; if (pulse_width !== PW_W'(e)) begin failures++; $display("FAIL b2b_rev_pw frame %0d: got %0d want %0d", i, pulse_width, e); end
    end
    checks++; if (busy !== 1'b0 || at_target !== 1'b1) begin failures++; $display("FAIL b2b_done: busy=%b at_target=%b want 0/1", busy, at_target); end
  endtask

  task automatic test_nonmultiple();
    int e;
    do_reset();
    for (int i = 0; i < 3; i++) step();
    send_cmd(75300);
    exp_q.push_back(75300);
    exp_q.push_back(75300);
    wait_frame();
    e = exp_q.pop_front();
    checks++; if (pulse_width !== PW_W'(e)) begin failures++; $display("FAIL nonmult_pw: got %0d want %0d", pulse_width, e); end
    checks++; if (busy !== 1'b0 || at_target !== 1'b1) begin failures++; $display("FAIL nonmult_state: busy=%b at_target=%b want 0/1", busy, at_target); end
    wait_frame();
    e = exp_q.pop_front();
    checks++; if (pulse_width !== PW_W'(e)) begin failures++; $display("FAIL nonmult_hold: got %0d want %0d", pulse_width, e); end
  endtask

  task automatic test_enable();
    int e;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    send_cmd(80000);
    exp_q.push_back(75500);
    wait_frame();
    e = exp_q.pop_front();
    checks++; if (pulse_width !== PW_W'(e)) begin failures++; $display("FAIL en_first_pw: got %0d want %0d", pulse_width, e); end
    enable = 1'b0;
    for (int k = 0; k < 3; k++) exp_q.push_back(75500);
    for (int i = 0; i < 3; i++) begin
      wait_frame();
      e = exp_q.pop_front();
      checks++; if (pulse_width !== PW_W'(e)) begin failures++; $display("FAIL en_hold_pw frame %0d: got %0d want %0d", i, pulse_width, e); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL en_hold_busy frame %0d: got %b want 1", i, busy); end
    end
    enable = 1'b1;
    exp_q.push_back(76000);
    exp_q.push_back(76500);
    for (int i = 0; i < 2; i++) begin
      wait_frame();
      e = exp_q.pop_front();
      checks++; if (pulse_width !== PW_W'(e)) begin failures++; $display("FAIL en_resume_pw frame %0d: got %0d want %0d", i, pulse_width, e); end
    end
  endtask

  task automatic test_reset_mid();
    int e;
    int n;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    send_cmd(90000);
    exp_q.push_back(75500);
    exp_q.push_back(76000);
    for (int i = 0; i < 2; i++) begin
      wait_frame();
      e = exp_q.pop_front();
      checks++; if (pulse_width !== PW_W'(e)) begin failures++; $display("FAIL mid_pre_pw frame %0d: got %0d want %0d", i, pulse_width, e); end
    end
    send_cmd(60000);
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL mid_pending: ready=%b want 0", cmd_ready); end
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (pulse_width !== 17'd75000) begin failures++; $display("FAIL mid_rst_pw: got %0d want 75000", pulse_width); end
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || at_target !== 1'b1) begin failures++; $display("FAIL mid_rst_flags: ready=%b busy=%b at_target=%b want 1/0/1", cmd_ready, busy, at_target); end
    n = 0;
    do begin step(); n++; end while (!frame_start && n < FRAME + 4);
    checks++; if (n !== FRAME) begin failures++; $display("FAIL mid_restart: frame_start at %0d want %0d", n, FRAME); end
    checks++; if (pulse_width !== 17'd75000 || busy !== 1'b0 || at_target !== 1'b1) begin failures++; $display("FAIL mid_after: pw=%0d busy=%b at_target=%b want 75000/0/1", pulse_width, busy, at_target); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    enable    = 1'b1;
    cmd_valid = 1'b0;
    cmd_pw    = '0;
    test_reset();
    test_small_step();
    test_clamp();
    test_back_to_back();
    test_nonmultiple();
    test_enable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
